// File: rtl/stream_proc_pkg.sv
// Shared definitions for the pixel stream processor: mode codes, FSM states
// and the saturating clamp used by the convolution path.
package stream_proc_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_INVERT = 2'b01;
    localparam logic [1:0] MODE_CONV   = 2'b10;
    localparam logic [1:0] MODE_THRESH = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_e;

    // Clamp a signed value into [0, max_v]; the caller truncates to pixel width.
    function automatic logic signed [31:0] sat_pix(input logic signed [31:0] v,
                                                   input logic signed [31:0] max_v);
        if (v < 32'sd0) begin
            return 32'sd0;
        end else if (v > max_v) begin
            return max_v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two chained line memories: lb1 holds the previous line, lb2 the line before.
// Reads are combinational so a write at the same address returns the old data.
module conv_line_buffer #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 32,
    localparam int AW   = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [PIX_W-1:0] din_i,
    output logic [PIX_W-1:0] lb1_o,
    output logic [PIX_W-1:0] lb2_o
);

    logic [PIX_W-1:0] lb1_mem [IMG_W];
    logic [PIX_W-1:0] lb2_mem [IMG_W];

    assign lb1_o = lb1_mem[addr_i];
    assign lb2_o = lb2_mem[addr_i];

    // Push the new pixel into lb1 and age the displaced lb1 entry into lb2.
    always_ff @(posedge clk) begin
        if (we_i) begin
            lb1_mem[addr_i] <= din_i;
            lb2_mem[addr_i] <= lb1_mem[addr_i];
        end
    end

endmodule

// File: rtl/stream_conv_proc.sv
// Pixel stream processor: bypass / invert / 3x3 convolution / threshold with
// valid-ready handshakes on both sides and frame row/column tracking.
module stream_conv_proc
    import stream_proc_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int COEF_W = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            mode,
    input  logic [9*COEF_W-1:0]   kernel,
    input  logic [3:0]            shift,
    input  logic [PIX_W-1:0]      thresh,
    input  logic [PIX_W-1:0]      in_pixel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [PIX_W-1:0]      out_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int PROD_W = PIX_W + COEF_W + 1;
    localparam int SUM_W  = PROD_W + 4;
    localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
    localparam logic [PIX_W-1:0] PIX_MAX  = {PIX_W{1'b1}};

    state_e                state_q;
    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic [1:0]            mode_q;
    logic [9*COEF_W-1:0]   kernel_q;
    logic [3:0]            shift_q;
    logic [PIX_W-1:0]      thresh_q;
    logic                  busy_q, frame_done_q;
    logic [PIX_W-1:0]      out_pixel_q;
    logic                  out_valid_q, out_last_q;
    logic [PIX_W-1:0]      win_q [3][3];
    logic [PIX_W-1:0]      win_d [3][3];

    logic                  in_fire_s, out_fire_s, emit_s, frame_last_s;
    logic [1:0]            eff_mode_s;
    logic [9*COEF_W-1:0]   eff_kernel_s;
    logic [3:0]            eff_shift_s;
    logic [PIX_W-1:0]      eff_thresh_s;
    logic [PIX_W-1:0]      lb1_s, lb2_s, result_s, conv_pix_s;
    logic signed [COEF_W-1:0] coef_s;
    logic signed [PROD_W-1:0] pix_ext_s, coef_ext_s, prod_s;
    logic signed [SUM_W-1:0]  sum_s, shifted_s;

    assign in_ready     = rstn && (state_q != DRAIN) && (!out_valid_q || out_ready);
    assign in_fire_s    = in_valid && in_ready;
    assign out_fire_s   = out_valid_q && out_ready;
    assign frame_last_s = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign out_pixel    = out_pixel_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

    conv_line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb (
        .clk    (clk),
        .we_i   (in_fire_s),
        .addr_i (col_q),
        .din_i  (in_pixel),
        .lb1_o  (lb1_s),
        .lb2_o  (lb2_s)
    );

    // The first pixel of a frame is processed with the live configuration it latches.
    always_comb begin
        if (state_q == IDLE) begin
            eff_mode_s   = mode;
            eff_kernel_s = kernel;
            eff_shift_s  = shift;
            eff_thresh_s = thresh;
        end else begin
            eff_mode_s   = mode_q;
            eff_kernel_s = kernel_q;
            eff_shift_s  = shift_q;
            eff_thresh_s = thresh_q;
        end
    end

    // Window as it will look after this transfer; column 2 is the newest.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb2_s;
        win_d[1][2] = lb1_s;
        win_d[2][2] = in_pixel;
    end

    // Signed 3x3 multiply-accumulate, arithmetic shift and clamp.
    always_comb begin
        sum_s      = '0;
        coef_s     = '0;
        pix_ext_s  = '0;
        coef_ext_s = '0;
        prod_s     = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                coef_s     = eff_kernel_s[(r*3+c)*COEF_W +: COEF_W];
                pix_ext_s  = {{(COEF_W+1){1'b0}}, win_d[r][c]};
                coef_ext_s = {{(PIX_W+1){coef_s[COEF_W-1]}}, coef_s};
                prod_s     = pix_ext_s * coef_ext_s;
                sum_s      = sum_s + {{4{prod_s[PROD_W-1]}}, prod_s};
            end
        end
        shifted_s  = sum_s >>> eff_shift_s;
        conv_pix_s = PIX_W'(sat_pix({{(32-SUM_W){shifted_s[SUM_W-1]}}, shifted_s},
                                    {{(32-PIX_W){1'b0}}, PIX_MAX}));
    end

    // Per-mode result selection and whether this input produces an output.
    always_comb begin
        case (eff_mode_s)
            MODE_BYPASS: result_s = in_pixel;
            MODE_INVERT: result_s = PIX_MAX - in_pixel;
            MODE_CONV:   result_s = conv_pix_s;
            MODE_THRESH: result_s = (in_pixel >= eff_thresh_s) ? PIX_MAX : {PIX_W{1'b0}};
            default:     result_s = in_pixel;
        endcase
        if (eff_mode_s == MODE_CONV) begin
            emit_s = (row_q >= RW'(2)) && (col_q >= CW'(2));
        end else begin
            emit_s = 1'b1;
        end
    end

    // Sliding 3x3 window shifted on every accepted input.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (in_fire_s) begin
            win_q <= win_d;
        end
    end

    // Single output register: loads on input transfer, empties on output transfer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_pixel_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (in_fire_s) begin
            out_valid_q <= emit_s;
            out_last_q  <= emit_s && frame_last_s;
            if (emit_s) begin
                out_pixel_q <= result_s;
            end
        end else if (out_fire_s) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    // Frame sequencing: FSM, raster counters, captured config and status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= MODE_BYPASS;
            kernel_q     <= '0;
            shift_q      <= 4'd0;
            thresh_q     <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (in_fire_s) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
            case (state_q)
                IDLE: begin
                    busy_q <= in_fire_s;
                    if (in_fire_s) begin
                        mode_q   <= mode;
                        kernel_q <= kernel;
                        shift_q  <= shift;
                        thresh_q <= thresh;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    busy_q <= 1'b1;
                    if (in_fire_s && frame_last_s) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire_s && out_last_q) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
